// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared types and opcode helpers for the fetch sequencer
//   Contents: state_e FSM encoding, OP_JMP / OP_HLT opcode constants,
//             is_two_byte() opcode classifier helper.
package fetch_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      OPERAND,
      ISSUE,
      HALT,
      FAULT
   } state_e;

   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_HLT = 4'b1111;

   // Opcodes that carry an operand byte and go through the exec handshake.
   function automatic logic is_two_byte(input logic [3:0] i_opcode);
      return (i_opcode inside {4'b0100, 4'b0101, 4'b0110, 4'b0111,
                               4'b1000, 4'b1001, 4'b1010, 4'b1011,
                               4'b1101});
   endfunction

endpackage

// File: rtl/fetch_sequencer_classifier.sv
// rtl/fetch_sequencer_classifier.sv - combinational opcode class decoder
//   i_opcode   : instruction bits [6:3]
//   o_two_byte : opcode needs an operand byte and is issued
//   o_jmp      : opcode is JMP (operand byte is the target, never issued)
//   o_hlt      : opcode is HLT
module opcode_classifier
   import fetch_seq_pkg::*;
(
   input  logic [3:0] i_opcode,
   output logic       o_two_byte,
   output logic       o_jmp,
   output logic       o_hlt
);

   assign o_two_byte = is_two_byte(i_opcode);
   assign o_jmp      = (i_opcode == OP_JMP);
   assign o_hlt      = (i_opcode == OP_HLT);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/decode/issue controller owning the program counter
//   i_clk, i_rst (async, active-low), i_run
//   i_mem_valid, i_mem_data     : instruction memory return for o_pc_out
//   i_exec_ready                : execute unit accepts the issued instruction
//   o_fetch_req, o_pc_out       : instruction memory read request / address
//   o_exec_valid, o_exec_opcode, o_exec_instr, o_exec_operand, o_exec_two_byte
//   o_halted, o_fault           : sticky terminal states, cleared only by reset
module fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter int              PC_W          = 4,
   parameter int              INSTR_W       = 8,
   parameter logic [PC_W-1:0] RESET_PC      = '0,
   parameter int              FETCH_TIMEOUT = 15
)(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_run,
   input  logic               i_mem_valid,
   input  logic [INSTR_W-1:0] i_mem_data,
   input  logic               i_exec_ready,
   output logic               o_fetch_req,
   output logic [PC_W-1:0]    o_pc_out,
   output logic               o_exec_valid,
   output logic [3:0]         o_exec_opcode,
   output logic [INSTR_W-1:0] o_exec_instr,
   output logic [INSTR_W-1:0] o_exec_operand,
   output logic               o_exec_two_byte,
   output logic               o_halted,
   output logic               o_fault
);

   localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);

   state_e             r_state;
   state_e             w_next_state;
   logic [PC_W-1:0]    r_pc;
   logic [INSTR_W-1:0] r_ir;
   logic [INSTR_W-1:0] r_opr;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_two;
   logic               r_jmp;

   logic               w_mem_two;
   logic               w_mem_jmp;
   logic               w_mem_hlt;
   logic               w_timeout;
   logic               w_issue;

   // Decode happens once, on the byte returned in FETCH; the class flags are
   // registered with the IR so OPERAND and ISSUE do not re-decode.
   opcode_classifier u_classifier (
      .i_opcode   (i_mem_data[6:3]),
      .o_two_byte (w_mem_two),
      .o_jmp      (w_mem_jmp),
      .o_hlt      (w_mem_hlt)
   );

   // This waiting cycle is the FETCH_TIMEOUT-th one without data.
   assign w_timeout = (r_cnt == CNT_W'(FETCH_TIMEOUT - 1));

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      o_fetch_req  = 1'b0;
      o_exec_valid = 1'b0;
      o_halted     = 1'b0;
      o_fault      = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_run) w_next_state = FETCH;
         end
         FETCH: begin
            o_fetch_req = 1'b1;
            if (i_mem_valid) begin
               if (w_mem_hlt)                   w_next_state = HALT;
               else if (w_mem_jmp || w_mem_two) w_next_state = OPERAND;
               else                             w_next_state = ISSUE;
            end else if (w_timeout) begin
               w_next_state = FAULT;
            end
         end
         OPERAND: begin
            o_fetch_req = 1'b1;
            if (i_mem_valid) begin
               // A jump is an instruction boundary, so run is sampled here.
               if (r_jmp) w_next_state = i_run ? FETCH : IDLE;
               else       w_next_state = ISSUE;
            end else if (w_timeout) begin
               w_next_state = FAULT;
            end
         end
         ISSUE: begin
            o_exec_valid = 1'b1;
            if (i_exec_ready) w_next_state = i_run ? FETCH : IDLE;
         end
         HALT:    o_halted = 1'b1;
         FAULT:   o_fault  = 1'b1;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_pc  <= RESET_PC;
         r_ir  <= '0;
         r_opr <= '0;
         r_cnt <= '0;
         r_two <= 1'b0;
         r_jmp <= 1'b0;
      end else begin
         case (r_state)
            FETCH: begin
               if (i_mem_valid) begin
                  r_ir  <= i_mem_data;
                  r_two <= w_mem_two;
                  r_jmp <= w_mem_jmp;
                  r_pc  <= r_pc + PC_W'(1);
                  r_cnt <= '0;
                  // Single-byte instructions issue with a zero operand.
                  if (!w_mem_two && !w_mem_jmp) r_opr <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            OPERAND: begin
               if (i_mem_valid) begin
                  r_opr <= i_mem_data;
                  r_pc  <= r_jmp ? i_mem_data[PC_W-1:0] : r_pc + PC_W'(1);
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Exec payload is only presented while the handshake is open.
   assign w_issue         = (r_state == ISSUE);
   assign o_pc_out        = r_pc;
   assign o_exec_opcode   = w_issue ? r_ir[6:3] : 4'b0000;
   assign o_exec_instr    = w_issue ? r_ir      : '0;
   assign o_exec_operand  = w_issue ? r_opr     : '0;
   assign o_exec_two_byte = w_issue & r_two;

endmodule
